fifo_stream_reader: RTL

Read-side controller for the team's synchronous FIFO. It pops words through the FIFO's `rd_en`/`rd_data`/`empty` port and absorbs the FIFO's one-cycle registered read latency. It re-presents the words downstream as a valid/ready stream at up to one word per cycle, with a `m_last` flag every `BURST_LEN` words. It sits between a `sync_fifo` instance and any consumer that needs back-pressure.

---
 rtl/fifo_pkg.sv | 18 +
 rtl/fifo_rd_skid.sv | 44 ++++
 rtl/fifo_stream_reader.sv | 72 +++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared constants for the FIFO read-side stream controller.
package fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_TWO   = 2'd2;

    function automatic logic [1:0] occ_step(
        input logic [1:0] occ,
        input logic       cap,
        input logic       pop
    );
        return occ + {1'b0, cap} - {1'b0, pop};
    endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry in-order buffer: entry e0 is always the head.
module fifo_rd_skid
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  capture,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [1:0]            occ
);

    logic [DATA_WIDTH-1:0] e0;
    logic [DATA_WIDTH-1:0] e1;
    logic [1:0]            tail;

    // Tail slot after this cycle's pop has shifted e1 into e0.
    assign tail = occ - {1'b0, pop};
    assign dout = e0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ <= OCC_EMPTY;
            e0  <= '0;
            e1  <= '0;
        end else begin
            occ <= occ_step(occ, capture, pop);
            if (pop) begin
                e0 <= e1;
            end
            if (capture) begin
                if (tail == OCC_EMPTY) begin
                    e0 <= din;
                end else begin
                    e1 <= din;
                end
            end
        end
    end

endmodule

// File: rtl/fifo_stream_reader.sv
// Pops a registered-read FIFO and re-presents words as a framed
// valid/ready stream at up to one word per cycle.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int BURST_LEN  = 4,
    parameter int CNT_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  idle
);

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(BURST_LEN - 1);

    logic [1:0]           occ;
    logic                 inflight;
    logic [CNT_WIDTH-1:0] bcnt;
    logic                 pop;
    logic                 issue;
    logic [2:0]           owed;

    assign m_valid = (occ != OCC_EMPTY);
    assign pop     = m_valid & m_ready;
    assign owed    = {1'b0, occ} + {2'b00, inflight};

    // A pop this cycle frees the slot a new read would land in.
    assign issue = enable & ~fifo_empty & ~rst
                 & ((owed <= 3'd1) | pop);
    assign fifo_rd_en = issue;

    assign m_last = m_valid & (bcnt == LAST_CNT);
    assign idle   = ~m_valid & ~inflight & (bcnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= 1'b0;
            bcnt     <= '0;
        end else begin
            inflight <= issue;
            if (pop) begin
                if (bcnt == LAST_CNT) begin
                    bcnt <= '0;
                end else begin
                    bcnt <= bcnt + CNT_WIDTH'(1);
                end
            end
        end
    end

    fifo_rd_skid #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk    (clk),
        .rst    (rst),
        .capture(inflight),
        .din    (fifo_rd_data),
        .pop    (pop),
        .dout   (m_data),
        .occ    (occ)
    );

endmodule
